mem_arbiter: RTL



---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arb_fsm.sv | 74 +++++++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data arbiter in front of mem_system.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_fsm.sv
// Arbiter control: state register, last-owner tracking, grant and latch enable.
module mem_arb_fsm
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_pend,
    input  logic       d_pend,
    input  logic       mem_done,
    output arb_state_t state,
    output logic       grant,
    output logic       grant_d
);

    arb_state_t state_nx;
    arb_owner_t last_own;
    arb_owner_t last_own_nx;
    logic       port_free;
    logic       prefer_d;

    // State and last-owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_own <= OWN_I;
        end else begin
            state    <= state_nx;
            last_own <= last_own_nx;
        end
    end

    // Next-state and grant: the port is free in IDLE or on the completing cycle,
    // and a tie goes to whichever port did not own the last completed access.
    always_comb begin
        state_nx    = state;
        last_own_nx = last_own;
        grant       = 1'b0;
        grant_d     = 1'b0;
        port_free   = 1'b0;
        prefer_d    = (last_own == OWN_I);
        case (state)
            IDLE: begin
                port_free = 1'b1;
            end
            BUSY_I: begin
                if (mem_done) begin
                    port_free   = 1'b1;
                    last_own_nx = OWN_I;
                    prefer_d    = 1'b1;
                end
            end
            BUSY_D: begin
                if (mem_done) begin
                    port_free   = 1'b1;
                    last_own_nx = OWN_D;
                    prefer_d    = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (port_free) begin
            if (i_pend || d_pend) begin
                grant    = 1'b1;
                grant_d  = d_pend && (!i_pend || prefer_d);
                state_nx = grant_d ? BUSY_D : BUSY_I;
            end else begin
                state_nx = IDLE;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_system between fetch and the data-memory stage. The granted
// request is latched and held on the memory port until mem_done; mem_stall is
// informational only and does not affect completion.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_data,
    output logic              i_done,
    output logic              i_stall,
    output logic              i_err,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_dump,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_createdump,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_done,
    input  logic              mem_stall,
    input  logic              mem_err
);

    arb_state_t        state;
    logic              grant;
    logic              grant_d;
    logic              d_pend;
    logic              busy_i;
    logic              busy_d;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_rd;
    logic              lat_wr;
    logic              lat_dump;
    logic              unused_mem_stall;

    assign d_pend           = d_rd | d_wr;
    assign unused_mem_stall = mem_stall;

    mem_arb_fsm u_fsm (
        .clk      (clk),
        .rst      (rst),
        .i_pend   (i_req),
        .d_pend   (d_pend),
        .mem_done (mem_done),
        .state    (state),
        .grant    (grant),
        .grant_d  (grant_d)
    );

    // Request latches, loaded on every grant; a simultaneous rd+wr is a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_rd    <= 1'b0;
            lat_wr    <= 1'b0;
            lat_dump  <= 1'b0;
        end else if (grant) begin
            if (grant_d) begin
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata;
                lat_rd    <= d_rd & ~d_wr;
                lat_wr    <= d_wr;
                lat_dump  <= d_dump;
            end else begin
                lat_addr  <= i_addr;
                lat_wdata <= '0;
                lat_rd    <= 1'b1;
                lat_wr    <= 1'b0;
                lat_dump  <= 1'b0;
            end
        end
    end

    // Memory port driven only from the latches, and only while an access is owned.
    always_comb begin
        mem_addr       = '0;
        mem_data_in    = '0;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        mem_createdump = 1'b0;
        if (state != IDLE) begin
            mem_addr       = lat_addr;
            mem_data_in    = lat_wdata;
            mem_rd         = lat_rd;
            mem_wr         = lat_wr;
            mem_createdump = lat_dump;
        end
    end

    // Route completion, data and error back to the owning port; stalls are combinational.
    always_comb begin
        busy_i  = (state == BUSY_I);
        busy_d  = (state == BUSY_D);
        i_done  = busy_i & mem_done;
        d_done  = busy_d & mem_done;
        i_err   = busy_i & mem_err;
        d_err   = busy_d & mem_err;
        i_data  = i_done ? mem_data_out : '0;
        d_rdata = d_done ? mem_data_out : '0;
        i_stall = i_req & ~i_done;
        d_stall = d_pend & ~d_done;
    end

endmodule
